pipe_stage_skid: RTL
====================

Name: pipe_stage_skid

Overview:
- Parametrised pipeline stage register for the CPU datapath. It is the successor to the fixed-field, stall-driven stage latches.
- Carries an opaque DATA_W payload. The team packs pc, operands, imm, rd and op into this payload.
- Uses valid/ready handshaking on both sides, with a synchronous flush for branch/jump squash.
- Has an optional two-entry skid buffer, so in_ready is a registered signal and the ready path is cut between stages.

Parameters:
- DATA_W, 32: payload width in bits, minimum 1.
- SKID, 1: 1 selects a two-entry skid buffer with registered in_ready. 0 selects a single register with combinational in_ready.
- RST_DATA, 0: value loaded into out_data on reset. Use the NOP encoding for op fields.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- rdy  in  1  global chip enable. When 0, no state changes and no handshake completes.
- flush  in  1  squash all held entries this cycle.
- in_valid  in  1  upstream has a payload.
- in_ready  out  1  stage can accept a payload.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  out_data holds a valid payload.
- out_ready  in  1  downstream accepts the payload.
- out_data  out  DATA_W  payload presented downstream.
- occupancy  out  2  number of entries held (0..2; 0..1 when SKID=0).

Behaviour:
- Transfer definitions:
  - in_fire = in_valid & in_ready & rdy.
  - out_fire = out_valid & out_ready & rdy.
- Reset:
  - out_valid=0, occupancy=0, out_data=RST_DATA, skid register=RST_DATA.
  - in_ready=1 in the first cycle after reset is released.
  - Reset overrides flush and rdy.
- Priority order: rst > flush > rdy-gated normal operation.

SKID=1 state machine (state is held in occupancy):
- EMPTY (0):
  - in_ready=1, out_valid=0.
  - in_fire: main<=in_data, go to ONE.
- ONE (1):
  - in_ready=1, out_valid=1.
  - in_fire & out_fire: main<=in_data, stay in ONE.
  - in_fire & !out_fire: skid<=in_data, go to FULL. main is unchanged.
  - !in_fire & out_fire: go to EMPTY.
  - neither: hold.
- FULL (2):
  - in_ready=0, out_valid=1.
  - out_fire: main<=skid, go to ONE.
  - no out_fire: hold.
- in_ready is a flop output, equal to (next occupancy != 2). It has no combinational path from out_ready.
- Ordering is strictly FIFO: the skid entry is always presented after the main entry.

SKID=0:
- One register.
- in_ready = !out_valid | out_ready, combinational. rdy is not included in in_ready.
- in_fire: main<=in_data and out_valid<=1.
- out_fire without in_fire: out_valid<=0.

Flush:
- Next cycle: out_valid=0, occupancy=0, in_ready=1.
- Any in_fire in the flush cycle is discarded, since upstream is flushed in the same cycle.
- Payload registers may keep stale data and are not cleared.

Stall / hold rules:
- rdy=0 freezes all state, including across a FULL condition.
- While out_valid=1 and no out_fire, out_data is stable. It is never overwritten by in_data.

Latency and throughput:
- 1 cycle from in_fire to out_valid.
- Throughput is 1 payload per cycle when out_ready is held at 1.

Payload width:
- out_data is exactly DATA_W bits, with no truncation or extension.

Test Plan:
- Reset, then stream payloads 0x11,0x22,0x33 with out_ready=1 -> out_valid rises 1 cycle after each accept; out_data sequence 0x11,0x22,0x33 back-to-back; occupancy stays 1.
- Fill with out_ready=0, accepting 0xA1 then 0xA2 -> occupancy=2, in_ready=0 the following cycle, out_data holds 0xA1. Raise out_ready -> outputs 0xA1 then 0xA2; in_ready returns to 1 one cycle after the first out_fire.
- FULL with 0xB1/0xB2, assert flush for 1 cycle while in_valid=1 with 0xB3 -> next cycle out_valid=0, occupancy=0, in_ready=1; 0xB3 never appears on out_data.
- Hold rdy=0 for 5 cycles with in_valid=1, out_ready=1, occupancy=1 -> no change in out_data, occupancy or in_ready. Resume -> correct ordering.
- Assert rst mid-stream at occupancy=2 -> next cycle out_valid=0, occupancy=0, out_data=RST_DATA. The first post-reset payload 0xC1 is delivered correctly.
- SKID=0, DATA_W=8: random in_valid/out_ready for 10k cycles against a reference queue -> no loss, no duplication, in_ready == (!out_valid | out_ready) every cycle.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Datapath pipeline stage: valid/ready register with optional two-entry skid buffer.
// SKID=1 registers in_ready so the ready path is cut between stages; SKID=0 is a plain register.
module pipe_stage_skid #(
   parameter int unsigned       DATA_W   = 32,
   parameter int unsigned       SKID     = 1,
   parameter logic [DATA_W-1:0] RST_DATA = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy
);

   typedef enum logic [1:0] {
      StEmpty = 2'd0,
      StOne   = 2'd1,
      StFull  = 2'd2
   } state_e;

   if (SKID != 0) begin : g_skid
      state_e            state_q;
      logic [DATA_W-1:0] main_q;
      logic [DATA_W-1:0] skid_q;
      logic              in_ready_q;
      logic              in_fire;
      logic              out_fire;

      assign in_fire  = in_valid & in_ready_q & rdy;
      assign out_fire = (state_q != StEmpty) & out_ready & rdy;

      // in_ready_q always tracks (next state != StFull), set alongside each transition.
      always_ff @(posedge clk) begin
         if (rst) begin
            state_q    <= StEmpty;
            main_q     <= RST_DATA;
            skid_q     <= RST_DATA;
            in_ready_q <= 1'b1;
         end else if (flush) begin
            state_q    <= StEmpty;
            in_ready_q <= 1'b1;
         end else if (rdy) begin
            case (state_q)
               StEmpty: begin
                  if (in_fire) begin
                     main_q  <= in_data;
                     state_q <= StOne;
                  end
               end
               StOne: begin
                  if (in_fire && out_fire) begin
                     main_q <= in_data;
                  end else if (in_fire) begin
                     skid_q     <= in_data;
                     state_q    <= StFull;
                     in_ready_q <= 1'b0;
                  end else if (out_fire) begin
                     state_q <= StEmpty;
                  end
               end
               StFull: begin
                  if (out_fire) begin
                     main_q     <= skid_q;
                     state_q    <= StOne;
                     in_ready_q <= 1'b1;
                  end
               end
               default: begin
                  state_q    <= StEmpty;
                  in_ready_q <= 1'b1;
               end
            endcase
         end
      end

      assign in_ready  = in_ready_q;
      assign out_valid = (state_q != StEmpty);
      assign out_data  = main_q;
      assign occupancy = state_q;
   end else begin : g_reg
      logic              valid_q;
      logic [DATA_W-1:0] main_q;
      logic              in_fire;
      logic              out_fire;

      // rdy deliberately not folded into in_ready; it only gates the fires.
      assign in_ready = ~valid_q | out_ready;
      assign in_fire  = in_valid & in_ready & rdy;
      assign out_fire = valid_q & out_ready & rdy;

      always_ff @(posedge clk) begin
         if (rst) begin
            valid_q <= 1'b0;
            main_q  <= RST_DATA;
         end else if (flush) begin
            valid_q <= 1'b0;
         end else if (in_fire) begin
            main_q  <= in_data;
            valid_q <= 1'b1;
         end else if (out_fire) begin
            valid_q <= 1'b0;
         end
      end

      assign out_valid = valid_q;
      assign out_data  = main_q;
      assign occupancy = {1'b0, valid_q};
   end

endmodule
